// File: rtl/mips_lsu_pkg.sv
// rtl/mips_lsu_pkg.sv - shared types, byte-enable constants and op decode helpers for the MIPS LSU
package mips_lsu_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LB  = 3'd1,
        OP_LBU = 3'd2,
        OP_LH  = 3'd3,
        OP_LHU = 3'd4,
        OP_SW  = 3'd5,
        OP_SB  = 3'd6,
        OP_SH  = 3'd7
    } lsu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    function automatic logic is_store(lsu_op_t op);
        return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
    endfunction

    function automatic lsu_size_t op_size(lsu_op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic op_signed(lsu_op_t op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/mips_bus_lsu_if.sv
// rtl/mips_bus_lsu_if.sv - core request/response and Avalon master signals of the LSU
interface mips_bus_lsu_if
    import mips_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    lsu_op_t           op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              err;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [3:0]        byteenable;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;

    modport master (
        input  req, op, addr, wdata, waitrequest, readdata,
        output busy, done, rdata, err, address, read, write, writedata, byteenable
    );

    modport slave (
        output req, op, addr, wdata, waitrequest, readdata,
        input  busy, done, rdata, err, address, read, write, writedata, byteenable
    );

endinterface

// File: rtl/mips_lsu_lane.sv
// rtl/mips_lsu_lane.sv - byte-lane steering: enables and replicated store data out, extended load data in
module mips_lsu_lane
    import mips_lsu_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [1:0]  ofs,
    input  logic [31:0] wdata,
    input  logic [31:0] readdata,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic [31:0] rdata
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        case (ofs)
            2'd1:    rd_byte = readdata[15:8];
            2'd2:    rd_byte = readdata[23:16];
            2'd3:    rd_byte = readdata[31:24];
            default: rd_byte = readdata[7:0];
        endcase
        rd_half = ofs[1] ? readdata[31:16] : readdata[15:0];
    end

    // Store data is replicated on every lane so the slave may pick any enabled byte.
    always_comb begin
        byteenable = BE_WORD;
        writedata  = wdata;
        rdata      = readdata;
        case (op_size(op))
            SZ_BYTE: begin
                byteenable = BE_BYTE0 << ofs;
                writedata  = {4{wdata[7:0]}};
                rdata      = op_signed(op) ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
            end
            SZ_HALF: begin
                byteenable = ofs[1] ? BE_HALF_HI : BE_HALF_LO;
                writedata  = {2{wdata[15:0]}};
                rdata      = op_signed(op) ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_bus_lsu.sv
// rtl/mips_bus_lsu.sv - load/store Avalon bus master for the multicycle core; MIPS_LSU_MISALIGN_TRAP_EN enables the misalignment trap
module mips_bus_lsu
    import mips_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    mips_bus_lsu_if.master bus
);

    lsu_state_t        state;
    lsu_op_t           op_q;
    logic [1:0]        ofs_q;

    lsu_op_t           lane_op;
    logic [1:0]        lane_ofs;
    logic [1:0]        req_ofs;
    logic              misaligned;
    logic [3:0]        lane_be;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_rdata;

    always_comb begin
        misaligned = 1'b0;
        req_ofs    = bus.addr[1:0];
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
        case (op_size(bus.op))
            SZ_HALF: misaligned = bus.addr[0];
            SZ_WORD: misaligned = |bus.addr[1:0];
            default: ;
        endcase
`else
        // Without the trap, offending low bits are dropped and the access runs aligned.
        case (op_size(bus.op))
            SZ_HALF: req_ofs = {bus.addr[1], 1'b0};
            SZ_WORD: req_ofs = 2'b00;
            default: ;
        endcase
`endif
    end

    // In IDLE the lane unit sees the incoming request; afterwards the latched one.
    assign lane_op  = (state == S_IDLE) ? bus.op  : op_q;
    assign lane_ofs = (state == S_IDLE) ? req_ofs : ofs_q;

    mips_lsu_lane u_lane (
        .op         (lane_op),
        .ofs        (lane_ofs),
        .wdata      (bus.wdata),
        .readdata   (bus.readdata),
        .byteenable (lane_be),
        .writedata  (lane_wdata),
        .rdata      (lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            op_q           <= OP_LW;
            ofs_q          <= 2'b00;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.rdata      <= '0;
            bus.address    <= '0;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.writedata  <= '0;
            bus.byteenable <= 4'b0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        op_q     <= bus.op;
                        ofs_q    <= req_ofs;
                        bus.busy <= 1'b1;
                        bus.err  <= 1'b0;
                        if (misaligned) begin
                            state     <= S_DONE;
                            bus.done  <= 1'b1;
                            bus.err   <= 1'b1;
                            bus.rdata <= '0;
                        end else begin
                            state          <= S_BUS;
                            bus.address    <= {bus.addr[ADDR_W-1:2], 2'b00};
                            bus.byteenable <= lane_be;
                            bus.writedata  <= lane_wdata;
                            bus.read       <= ~is_store(bus.op);
                            bus.write      <= is_store(bus.op);
                        end
                    end
                end
                S_BUS: begin
                    if (!bus.waitrequest) begin
                        state     <= S_DONE;
                        bus.read  <= 1'b0;
                        bus.write <= 1'b0;
                        bus.done  <= 1'b1;
                        if (!is_store(op_q)) begin
                            bus.rdata <= lane_rdata;
                        end
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    bus.busy  <= 1'b0;
                    bus.done  <= 1'b0;
                    bus.read  <= 1'b0;
                    bus.write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_lsu.sv
// tb/tb_mips_bus_lsu.sv - randomized and directed self-checking bench for mips_bus_lsu
module tb_mips_bus_lsu;
    import mips_lsu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_bus_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mips_bus_lsu #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_vec  = 0;
    int n_fail = 0;
    logic [31:0] mem [0:63];
    logic [31:0] exp_rdata;

    function automatic int size_of(lsu_op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            default:              return 4;
        endcase
    endfunction

    function automatic bit is_st(lsu_op_t op);
        return op == OP_SW || op == OP_SB || op == OP_SH;
    endfunction

    function automatic bit is_misaligned(lsu_op_t op, logic [31:0] a);
        return (int'(a[1:0]) % size_of(op)) != 0;
    endfunction

    function automatic int eff_off(lsu_op_t op, logic [31:0] a);
        return (int'(a[1:0]) / size_of(op)) * size_of(op);
    endfunction

    function automatic logic [3:0] exp_be(lsu_op_t op, int off);
        int m;
        m = ((1 << size_of(op)) - 1) << off;
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wd(lsu_op_t op, logic [31:0] wd);
        case (size_of(op))
            1:       return {24'd0, wd[7:0]} * 32'h01010101;
            2:       return {16'd0, wd[15:0]} * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_val(lsu_op_t op, logic [31:0] w, int off);
        logic [31:0] s;
        s = w >> (8 * off);
        case (op)
            OP_LB:  begin s = s & 32'hFF;   if (s[7])  s = s | 32'hFFFFFF00; end
            OP_LBU: s = s & 32'hFF;
            OP_LH:  begin s = s & 32'hFFFF; if (s[15]) s = s | 32'hFFFF0000; end
            OP_LHU: s = s & 32'hFFFF;
            default: ;
        endcase
        return s;
    endfunction

    // Runs one access from the IDLE cycle (posedge+1) and returns in the next IDLE cycle.
    task automatic access(input lsu_op_t op, input logic [31:0] a, input logic [31:0] wd,
                          input int waits, input string tag);
        bit st;
        bit trap_hit;
        int off;
        int idx;
        logic [3:0]  be;
        logic [31:0] wdx;
        logic [31:0] w;
        st  = is_st(op);
        off = eff_off(op, a);
        idx = int'(a[7:2]);
        be  = exp_be(op, off);
        wdx = exp_wd(op, wd);
        trap_hit = 1'b0;
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
        trap_hit = is_misaligned(op, a);
`endif
        bus.req = 1'b1; bus.op = op; bus.addr = a; bus.wdata = wd;
        @(posedge clk); #1;
        bus.req = 1'b0;
        if (trap_hit) begin
            exp_rdata = 32'd0;
        end else begin
            for (int c = 1; c <= waits + 1; c++) begin
                n_vec++;
                if ({bus.read, bus.write} !== {~st, st}) begin
                    n_fail++;
                    $display("FAIL %s rd/wr c%0d: got %b%b want %b%b", tag, c, bus.read, bus.write, ~st, st);
                end
                n_vec++;
                if (bus.address !== {a[31:2], 2'b00}) begin
                    n_fail++;
                    $display("FAIL %s address c%0d: got %h want %h", tag, c, bus.address, {a[31:2], 2'b00});
                end
                n_vec++;
                if (bus.byteenable !== be) begin
                    n_fail++;
                    $display("FAIL %s byteenable c%0d: got %b want %b", tag, c, bus.byteenable, be);
                end
                if (st) begin
                    n_vec++;
                    if (bus.writedata !== wdx) begin
                        n_fail++;
                        $display("FAIL %s writedata c%0d: got %h want %h", tag, c, bus.writedata, wdx);
                    end
                end
                n_vec++;
                if ({bus.busy, bus.done} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL %s busy/done in bus c%0d: got %b%b want 10", tag, c, bus.busy, bus.done);
                end
                bus.req   = 1'($urandom);
                bus.op    = lsu_op_t'($urandom_range(0, 7));
                bus.addr  = $urandom;
                bus.wdata = $urandom;
                bus.waitrequest = (c <= waits);
                bus.readdata    = (c <= waits) ? $urandom : mem[idx];
                if (c == waits + 1) begin
                    if (st) begin
                        w = mem[idx];
                        for (int k = 0; k < 4; k++)
                            if (be[k]) w[8*k +: 8] = wdx[8*k +: 8];
                        mem[idx] = w;
                    end else begin
                        exp_rdata = load_val(op, mem[idx], off);
                    end
                end
                @(posedge clk); #1;
            end
        end
        n_vec++;
        if ({bus.done, bus.busy, bus.read, bus.write} !== 4'b1100) begin
            n_fail++;
            $display("FAIL %s done cycle d/b/r/w: got %b%b%b%b want 1100", tag, bus.done, bus.busy, bus.read, bus.write);
        end
        n_vec++;
        if (bus.err !== trap_hit) begin
            n_fail++;
            $display("FAIL %s err: got %b want %b", tag, bus.err, trap_hit);
        end
        n_vec++;
        if (bus.rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL %s rdata: got %h want %h", tag, bus.rdata, exp_rdata);
        end
        bus.req  = 1'($urandom);
        bus.op   = lsu_op_t'($urandom_range(0, 7));
        bus.addr = $urandom;
        bus.waitrequest = 1'($urandom);
        @(posedge clk); #1;
        bus.req = 1'b0;
        n_vec++;
        if ({bus.done, bus.busy, bus.read, bus.write} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s after done d/b/r/w: got %b%b%b%b want 0000", tag, bus.done, bus.busy, bus.read, bus.write);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.busy, bus.done, bus.read, bus.write, bus.err, bus.byteenable} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset ctl: got %b%b%b%b%b be %b want all 0", bus.busy, bus.done, bus.read, bus.write, bus.err, bus.byteenable);
        end
        n_vec++;
        if ({bus.rdata, bus.address, bus.writedata} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset data: got %h %h %h want 0", bus.rdata, bus.address, bus.writedata);
        end
        reset = 1'b0;
        exp_rdata = 32'd0;
    endtask

    task automatic test_directed();
        logic [31:0] v;
        mem[0] = 32'hDEADBEEF;
        access(OP_LW, 32'h00001000, 32'd0, 0, "lw");
        n_vec++;
        if (bus.rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL lw const: got %h want deadbeef", bus.rdata);
        end
        mem[0] = 32'h80123456;
        access(OP_LB, 32'h00001003, 32'd0, 0, "lb");
        n_vec++;
        if (bus.rdata !== 32'hFFFFFF80) begin
            n_fail++;
            $display("FAIL lb const: got %h want ffffff80", bus.rdata);
        end
        access(OP_LBU, 32'h00001003, 32'd0, 0, "lbu");
        n_vec++;
        if (bus.rdata !== 32'h00000080) begin
            n_fail++;
            $display("FAIL lbu const: got %h want 00000080", bus.rdata);
        end
        access(OP_SH, 32'h00001002, 32'h1234ABCD, 0, "sh");
        v = mem[0];
        n_vec++;
        if (v !== 32'hABCD3456) begin
            n_fail++;
            $display("FAIL sh merged word: got %h want abcd3456", v);
        end
        n_vec++;
        if (bus.rdata !== 32'h00000080) begin
            n_fail++;
            $display("FAIL sh rdata kept: got %h want 00000080", bus.rdata);
        end
        mem[0] = 32'h5A5AC3F1;
        access(OP_LHU, 32'h00002000, 32'd0, 3, "lhu_wait");
        n_vec++;
        if (bus.rdata !== 32'h0000C3F1) begin
            n_fail++;
            $display("FAIL lhu const: got %h want 0000c3f1", bus.rdata);
        end
        access(OP_LH, 32'h00002000, 32'd0, 1, "lh_wait");
        access(OP_LW, 32'h00001001, 32'd0, 0, "lw_misalign");
        access(OP_SW, 32'h00001003, 32'hCAFEF00D, 2, "sw_misalign");
        access(OP_LHU, 32'h00001003, 32'd0, 0, "lhu_misalign");
    endtask

    task automatic test_reset_inflight();
        bus.req = 1'b1; bus.op = OP_LW; bus.addr = 32'h00003000; bus.waitrequest = 1'b1;
        @(posedge clk); #1;
        bus.req = 1'b0;
        n_vec++;
        if ({bus.read, bus.busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL inflight start r/b: got %b%b want 11", bus.read, bus.busy);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.waitrequest = 1'b0;
        exp_rdata = 32'd0;
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if ({bus.read, bus.write, bus.busy, bus.done} !== 4'b0000) begin
                n_fail++;
                $display("FAIL inflight reset c%0d r/w/b/d: got %b%b%b%b want 0000", c, bus.read, bus.write, bus.busy, bus.done);
            end
            @(posedge clk); #1;
        end
        mem[0] = 32'h13579BDF;
        access(OP_LW, 32'h00001000, 32'd0, 0, "lw_after_reset");
    endtask

    task automatic test_random();
        lsu_op_t op;
        for (int i = 0; i < 150; i++) begin
            op = lsu_op_t'($urandom_range(0, 7));
            access(op, $urandom, $urandom, int'($urandom_range(0, 3)), "rand");
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        exp_rdata = 32'd0;
        reset = 1'b1;
        bus.req = 1'b0; bus.op = OP_LW; bus.addr = 32'd0; bus.wdata = 32'd0;
        bus.waitrequest = 1'b0; bus.readdata = 32'd0;
        test_reset();
        test_directed();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
